mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter that sits on the multicycle MIPS core's data-memory write path as a responder.
//  The core's store to TXDATA launches an 8N1 frame on tx_o; STATUS is read back for polling.
//  Companion to the GPIO input path: carries data out of the core instead of into it.
// PARAMETERS
//  WIDTH     32            data/address bus width
//  BASE_ADDR 32'h1001_0024 byte address of TXDATA; STATUS = BASE_ADDR+4
//  BAUD_DIV  434           clk cycles per UART bit (50 MHz / 115200); must be >= 2
// PORTS
//  clk      in  1      system clock, rising edge
//  rst      in  1      asynchronous, active-low reset
//  addr_i   in  WIDTH  byte address from core (ALU result / IorD mux)
//  wdata_i  in  WIDTH  store data from core
//  we_i     in  1      MemWrite strobe, one cycle per store
//  rdata_o  out WIDTH  read data for addr_i (combinational); 0 when addr_i is not a register address
//  tx_o     out 1      serial line, idles high
//  busy_o   out 1      frame in progress (mirror of STATUS[0])
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, tx_o=1, busy_o=0, shift reg=0, baud cnt=0, bit idx=0, done=0, ovr=0.
//  Decode: full-word compare of addr_i with BASE_ADDR / BASE_ADDR+4; other addresses ignored (no effect).
//  STATUS read = {29'b0, ovr, done, busy}; reads have no side effects.
//  Write TXDATA in IDLE: latch wdata_i[7:0], go START, busy_o=1 and tx_o=0 from the next edge.
//  Write TXDATA while busy: data dropped, ovr<=1 (sticky); frame in flight unaffected.
//  Write STATUS: wdata_i[1]=1 clears done; wdata_i[2]=1 clears ovr; other bits ignored.
//  FSM: IDLE -> START (1 bit) -> DATA (8 bits, LSB first) -> STOP (1 bit, tx_o=1) -> IDLE.
//  Each bit held exactly BAUD_DIV cycles; baud cnt runs 0..BAUD_DIV-1 and wraps at bit boundary.
//  Frame length = 10*BAUD_DIV cycles from first tx_o=0 cycle to return to IDLE.
//  End of STOP: busy_o<=0, done<=1 on the same edge (done set wins over a simultaneous STATUS clear).
//  Write TXDATA in the first cycle busy_o=0 is accepted (back-to-back frames, no extra idle gap).
//  Reset mid-frame: frame aborted, tx_o returns high immediately, all state as at reset.
//  No flow control, no FIFO: one byte in flight; software must poll busy.
// TESTING
//  Reset: rst=0 mid-idle -> tx_o=1, busy_o=0, rdata_o@STATUS=0.
//  BAUD_DIV=4, store 32'h0000_00A5 to TXDATA -> tx_o bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy 40 cycles; STATUS=32'h2.
//  Store 8'h55 then 8'h33 at cycle 10 of the frame -> only 55 sent, STATUS=32'h5 while busy, 32'h6 after.
//  Store STATUS 32'h6 -> STATUS=0; store 8'hFF to BASE_ADDR+8 -> no frame, tx_o stays 1.
//  Assert rst=0 during bit 3 of a frame -> tx_o=1 same cycle; after release a new store sends a full clean frame.
//  Store issued on cycle busy_o falls -> second frame starts next edge, busy_o=0 for exactly one cycle.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory path.
// TXDATA at BASE_ADDR launches a frame; STATUS at BASE_ADDR+4 = {ovr, done, busy}.
module mmio_uart_tx #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   BASE_ADDR = 'h1001_0024,
    parameter int                 BAUD_DIV  = 434
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             we_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             tx_o,
    output logic             busy_o
);
    localparam int               CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]    BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [WIDTH-1:0] STAT_ADDR = BASE_ADDR + WIDTH'(4);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          wr_tx, wr_st, bit_end;

    assign wr_tx   = we_i && (addr_i == BASE_ADDR);
    assign wr_st   = we_i && (addr_i == STAT_ADDR);
    assign bit_end = (cnt_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        // Counter only runs inside a frame and wraps on each bit boundary, so it is 0 in IDLE.
        if (state_q != IDLE)
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE:  if (wr_tx) begin
                       state_d = START;
                       shift_d = wdata_i[7:0];
                   end
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end) begin
                       shift_d = shift_q >> 1;
                       idx_d   = idx_q + 3'd1;
                       if (idx_q == 3'd7) state_d = STOP;
                   end
            STOP:  if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wr_st) begin
            if (wdata_i[1]) done_d = 1'b0;
            if (wdata_i[2]) ovr_d  = 1'b0;
        end
        if (wr_tx && state_q != IDLE) ovr_d = 1'b1;
        // Completion beats a software clear landing on the same edge.
        if (state_q == STOP && bit_end) done_d = 1'b1;
    end

    // Line is decoded from state so an async reset forces it high at once.
    always_comb begin
        case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = shift_q[0];
            default: tx_o = 1'b1;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign rdata_o = (addr_i == STAT_ADDR) ? {{(WIDTH-3){1'b0}}, ovr_q, done_q, busy_o} : '0;

    logic unused_hi;
    assign unused_hi = ^wdata_i[WIDTH-1:8];
endmodule
